knn_ctrl: RTL and testbench
===========================

# knn_ctrl

Batch sequencer for the multi-solver kNN datapath (`knn`, N_SOLVERS parallel `pipeline_sorter` instances). It sits between two host-written point buffers (test points, training points) and the `knn` ports. For each batch it:

- clears the sorters,
- loads one test point per solver,
- streams every training point to all solvers at once,
- pulses DONE,
- reads out HW_K neighbour labels per solver over a valid/ready result port.

## Interface

Parameters:
- W, 32: point word width; {y[W-1:W/2], x[W/2-1:0]}.
- HW_K, 10: neighbours per solver (ranks 0..HW_K-1).
- N_SOLVERS, 4: solver count in the attached `knn`.
- ADDR_W, 10: buffer address width; max 2^ADDR_W training points.
- DRAIN, 12: flush cycles after the last valid, before DONE (≥ sorter pipeline depth).

Ports:
- clk in 1: clock.
- rst in 1: reset. One clock; reset is synchronous and active-high.
- start in 1: begin a batch; sampled only in IDLE.
- n_test in 16: number of test points. Clamped to N_SOLVERS.
- n_train in ADDR_W+1: number of training points, 0..2^ADDR_W.
- busy out 1: high from the cycle after accepted start until FIN completes.
- done out 1: one-cycle pulse when the batch completes.
- test_rd out 1, test_addr out ADDR_W, test_data in W: test buffer read port; data valid 1 cycle after test_rd.
- train_rd out 1, train_addr out ADDR_W, train_data in W: training buffer read port; same 1-cycle latency.
- knn_rst out 1: sorter clear; equals rst OR (state==INIT).
- knn_data1 out W, knn_data2 out W, knn_solver_sel out W/2, knn_valid out 1, knn_done out 1, knn_sel out 16: drive the `knn` ports DATA_1, DATA_2, SOLVER_SEL, valid, DONE, SEL.
- knn_data_out in 8: `knn` DATA_OUT.
- res_valid out 1, res_data out 8, res_solver out 16, res_rank out 16, res_ready in 1: result stream.

## Operation

States: IDLE, INIT, LOAD, STREAM, FLUSH, DONE, RSET, RPUT, FIN.

- **IDLE.** On start: latch nt = min(n_test, N_SOLVERS) and nn = n_train.
  - nt==0 → FIN.
  - otherwise → INIT.
- **INIT** (1 cycle): knn_rst=1 → LOAD.
- **LOAD.** Issue test_rd for addresses 0..nt-1, one per cycle.
  - One cycle after each read, drive knn_solver_sel=addr and knn_data1=test_data.
  - After the last write → STREAM, or → FLUSH if nn==0.
- **STREAM.** Issue train_rd for addresses 0..nn-1, one per cycle.
  - One cycle after each read, drive knn_valid=1 and knn_data2=train_data.
  - After the last valid → FLUSH.
- **FLUSH.** DRAIN cycles with knn_valid=0 → DONE.
- **DONE** (1 cycle): knn_done=1 → RSET with s=0, r=0.
- **RSET** (1 cycle): drive knn_solver_sel=s, knn_sel=r → RPUT.
- **RPUT.** On entry, register res_data=knn_data_out, res_solver=s, res_rank=r, and assert res_valid.
  - Hold all result outputs until res_ready.
  - On the handshake: r++. When r wraps at HW_K, r=0 and s++.
  - s==nt → FIN; otherwise → RSET.
- **FIN** (1 cycle): done=1, busy=0 next cycle → IDLE.

Solver-select rules:
- Whenever knn_solver_sel is not addressing a solver (IDLE, INIT, STREAM, FLUSH, DONE, FIN, and LOAD cycles without a write), it is all-ones. Solvers therefore never capture DATA_1 outside their own LOAD write.
- In RSET/RPUT knn_data1 holds its last value. The solver overwrite after DONE does not affect results.

Other rules:
- Solvers at index nt..N_SOLVERS-1 are neither loaded nor read.
- start while busy is ignored. rst in any state → IDLE with all outputs at reset values. The sorters are cleared through knn_rst.

Reset values: busy 0, done 0, test_rd/train_rd 0, addresses 0, knn_data1/knn_data2 0, knn_solver_sel all-ones, knn_valid 0, knn_done 0, knn_sel 0, res_valid 0, res_data/res_solver/res_rank 0. knn_rst is 1 while rst is high.

## Timing

- start accepted at cycle 0 → INIT at cycle 1. LOAD spans nt+1 cycles.
- STREAM spans nn+1 cycles: first knn_valid 1 cycle after the first train_rd; knn_valid is contiguous for nn cycles.
- FLUSH = DRAIN cycles, then DONE = 1 cycle.
- Readout takes at least 2 cycles per result (RSET+RPUT), with res_ready tied high.
- Total with res_ready=1: 1 + 1 + (nt+1) + (nn+1) + DRAIN + 1 + 2·nt·HW_K + 1 cycles.
- res_valid never drops before the handshake. res_* are stable while res_valid=1 and res_ready=0.

## Test plan

- **Reset:** rst for 3 cycles → every output at its reset value; knn_rst=1 throughout; start ignored during rst.
- **Basic batch:** nt=2, nn=5, res_ready=1 → knn_rst pulse 1 cycle; solver writes at sel 0 then 1; exactly 5 contiguous knn_valid cycles with train words in order; knn_done 1 cycle after DRAIN idle cycles; 20 results with (solver, rank) = (0,0)..(1,9); done after the last result; cycle count per the Timing formula.
- **Backpressure:** random res_ready at 30% → no result lost or duplicated; res_* held stable while stalled.
- **Edges:** n_test=0 → done within 2 cycles, no knn activity. n_train=0 → no knn_valid, still DRAIN+DONE+readout. n_test=9 with N_SOLVERS=4 → exactly 4 solvers loaded and read.
- **Abort:** rst asserted mid-STREAM and again mid-RPUT → IDLE next cycle, outputs reset; the following batch completes with correct results.
- **Start while busy:** start pulses during STREAM → ignored; single done pulse only.

Source files
------------

// File: rtl/knn_ctrl.sv
// Batch sequencer for the multi-solver kNN datapath: clears the sorters, loads one test point per
// solver, streams all training points to every solver, then reads HW_K labels per solver out over
// a valid/ready result port.
module knn_ctrl #(
    parameter int unsigned W         = 32,
    parameter int unsigned HW_K      = 10,
    parameter int unsigned N_SOLVERS = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DRAIN     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       n_test,
    input  logic [ADDR_W:0]   n_train,
    output logic              busy,
    output logic              done,
    output logic              test_rd,
    output logic [ADDR_W-1:0] test_addr,
    input  logic [W-1:0]      test_data,
    output logic              train_rd,
    output logic [ADDR_W-1:0] train_addr,
    input  logic [W-1:0]      train_data,
    output logic              knn_rst,
    output logic [W-1:0]      knn_data1,
    output logic [W-1:0]      knn_data2,
    output logic [W/2-1:0]    knn_solver_sel,
    output logic              knn_valid,
    output logic              knn_done,
    output logic [15:0]       knn_sel,
    input  logic [7:0]        knn_data_out,
    output logic              res_valid,
    output logic [7:0]        res_data,
    output logic [15:0]       res_solver,
    output logic [15:0]       res_rank,
    input  logic              res_ready
);

    localparam int unsigned SW = W / 2;

    typedef enum logic [3:0] {
        StIdle, StInit, StLoad, StStream, StFlush, StDone, StRset, StRput, StFin
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [15:0]       nt_q;
    logic [ADDR_W:0]   nn_q;
    logic [15:0]       s_q, s_d, r_q, r_d;
    logic [W-1:0]      data1_q, data2_q;
    logic              res_valid_q;
    logic [7:0]        res_data_q;
    logic [15:0]       res_solver_q, res_rank_q;
    logic [15:0]       nt_in;

    assign nt_in      = (32'(n_test) > N_SOLVERS) ? 16'(N_SOLVERS) : n_test;
    assign knn_rst    = rst | (state_q == StInit);
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_solver = res_solver_q;
    assign res_rank   = res_rank_q;

    // Next-state and output decode; the read-port counter cnt_q is shared by LOAD, STREAM, FLUSH.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        s_d            = s_q;
        r_d            = r_q;
        busy           = (state_q != StIdle);
        done           = (state_q == StFin);
        test_rd        = 1'b0;
        test_addr      = '0;
        train_rd       = 1'b0;
        train_addr     = '0;
        knn_solver_sel = '1;
        knn_data1      = data1_q;
        knn_data2      = data2_q;
        knn_valid      = 1'b0;
        knn_done       = 1'b0;
        knn_sel        = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = (nt_in == 16'd0) ? StFin : StInit;
                end
            end
            StInit: begin
                cnt_d   = '0;
                state_d = StLoad;
            end
            StLoad: begin
                if (cnt_q < {16'd0, nt_q}) begin
                    test_rd   = 1'b1;
                    test_addr = ADDR_W'(cnt_q);
                end
                // Write lags the read by one cycle to match the buffer latency.
                if (cnt_q != 32'd0) begin
                    knn_solver_sel = SW'(cnt_q - 32'd1);
                    knn_data1      = test_data;
                end
                if (cnt_q == {16'd0, nt_q}) begin
                    cnt_d   = '0;
                    state_d = (nn_q == '0) ? StFlush : StStream;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StStream: begin
                if (cnt_q < 32'(nn_q)) begin
                    train_rd   = 1'b1;
                    train_addr = ADDR_W'(cnt_q);
                end
                if (cnt_q != 32'd0) begin
                    knn_valid = 1'b1;
                    knn_data2 = train_data;
                end
                if (cnt_q == 32'(nn_q)) begin
                    cnt_d   = '0;
                    state_d = StFlush;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StFlush: begin
                if (cnt_q == 32'(DRAIN - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                knn_done = 1'b1;
                s_d      = '0;
                r_d      = '0;
                state_d  = StRset;
            end
            StRset: begin
                knn_solver_sel = SW'(s_q);
                knn_sel        = r_q;
                state_d        = StRput;
            end
            StRput: begin
                knn_solver_sel = SW'(s_q);
                knn_sel        = r_q;
                if (res_ready) begin
                    if (r_q == 16'(HW_K - 1)) begin
                        r_d     = '0;
                        s_d     = s_q + 16'd1;
                        state_d = (s_q + 16'd1 == nt_q) ? StFin : StRset;
                    end else begin
                        r_d     = r_q + 16'd1;
                        state_d = StRset;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, batch sizes, held datapath words and the registered result port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            nt_q         <= '0;
            nn_q         <= '0;
            s_q          <= '0;
            r_q          <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_solver_q <= '0;
            res_rank_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            data1_q <= knn_data1;
            data2_q <= knn_data2;
            if (state_q == StIdle && start) begin
                nt_q <= nt_in;
                nn_q <= n_train;
            end
            if (state_q == StRset) begin
                res_valid_q  <= 1'b1;
                res_data_q   <= knn_data_out;
                res_solver_q <= s_q;
                res_rank_q   <= r_q;
            end else if (state_q == StRput && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_knn_ctrl.sv
// Self-checking bench for knn_ctrl: buffer models, a stand-in knn whose labels depend on the
// loaded test words and the streamed training words, and a per-cycle timeline check.
module tb_knn_ctrl;
    localparam int W = 32, HW_K = 10, NS = 4, AW = 10, DRAIN = 12;

    logic            clk = 1'b0;
    logic            rst, start, res_ready;
    logic [15:0]     n_test;
    logic [AW:0]     n_train;
    logic            busy, done, test_rd, train_rd, knn_rst, knn_valid, knn_done, res_valid;
    logic [AW-1:0]   test_addr, train_addr;
    logic [W-1:0]    test_data, train_data, knn_data1, knn_data2;
    logic [W/2-1:0]  knn_solver_sel;
    logic [15:0]     knn_sel, res_solver, res_rank;
    logic [7:0]      knn_data_out, res_data;

    knn_ctrl #(.W(W), .HW_K(HW_K), .N_SOLVERS(NS), .ADDR_W(AW), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst), .start(start), .n_test(n_test), .n_train(n_train),
        .busy(busy), .done(done), .test_rd(test_rd), .test_addr(test_addr),
        .test_data(test_data), .train_rd(train_rd), .train_addr(train_addr),
        .train_data(train_data), .knn_rst(knn_rst), .knn_data1(knn_data1),
        .knn_data2(knn_data2), .knn_solver_sel(knn_solver_sel), .knn_valid(knn_valid),
        .knn_done(knn_done), .knn_sel(knn_sel), .knn_data_out(knn_data_out),
        .res_valid(res_valid), .res_data(res_data), .res_solver(res_solver),
        .res_rank(res_rank), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    logic [W-1:0] test_mem  [0:(1<<AW)-1];
    logic [W-1:0] train_mem [0:(1<<AW)-1];

    // Host buffers with one-cycle read latency.
    always @(posedge clk) begin
        if (test_rd)  test_data  <= test_mem[test_addr];
        if (train_rd) train_data <= train_mem[train_addr];
    end

    // Stand-in knn: label(s, r) = (loaded[s] ^ xor of streamed words) + r, low bytes only.
    logic [7:0] cap [NS];
    logic [7:0] acc;
    logic       load_ph;
    always @(posedge clk) begin
        if (knn_rst) begin
            for (int i = 0; i < NS; i++) cap[i] <= 8'h0;
            acc     <= 8'h0;
            load_ph <= 1'b1;
        end else begin
            if (load_ph && int'(knn_solver_sel) < NS) cap[int'(knn_solver_sel)] <= knn_data1[7:0];
            if (knn_valid) acc <= acc ^ knn_data2[7:0];
            if (knn_done) load_ph <= 1'b0;
        end
    end
    always_comb begin
        knn_data_out = 8'hFF;
        if (int'(knn_solver_sel) < NS)
            knn_data_out = (cap[int'(knn_solver_sel)] ^ acc) + knn_sel[7:0];
    end

    int checks = 0, failures = 0;
    int rq_s[$], rq_r[$], rq_d[$];
    int last_done_c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_rd"}, 64'({test_rd, train_rd}), 0);
        chk({tag, "_addr"}, 64'({test_addr, train_addr}), 0);
        chk({tag, "_data1"}, 64'(knn_data1), 0);
        chk({tag, "_data2"}, 64'(knn_data2), 0);
        chk({tag, "_ssel"}, 64'(knn_solver_sel), 64'(16'hFFFF));
        chk({tag, "_kv_kd_ksel"}, 64'({knn_valid, knn_done, knn_sel}), 0);
        chk({tag, "_res"}, 64'({res_valid, res_data, res_solver, res_rank}), 0);
    endtask

    function automatic logic [7:0] exp_lbl(input int s, input int r, input int nn);
        logic [7:0] x = 8'h0;
        for (int i = 0; i < nn; i++) x = x ^ train_mem[i][7:0];
        return (test_mem[s][7:0] ^ x) + 8'(r);
    endfunction

    // One batch: drives start, then checks every cycle against the timeline derived from
    // nt/nn/DRAIN; abort_c > 0 applies rst at that cycle instead of finishing.
    task automatic run_batch(input int ntest, input int ntrain, input int pct, input int abort_c,
                             input bit busy_start);
        int nt, nn, dk, fin_c, c, done_c, done_cnt, last_hs;
        bit prev_stall;
        logic [7:0] p_d;
        logic [15:0] p_s, p_r;
        nt = (ntest > NS) ? NS : ntest;
        nn = ntrain;
        dk = (nt == 0) ? -1 : nt + 3 + ((nn > 0) ? nn + 1 : 0) + DRAIN;
        fin_c = (nt == 0) ? 1 : dk + 2 * nt * HW_K + 1;
        rq_s.delete(); rq_d.delete(); rq_r.delete();
        done_c = -1; done_cnt = 0; last_hs = -1; prev_stall = 0; c = 0;
        p_d = 0; p_s = 0; p_r = 0;
        @(negedge clk);
        n_test = 16'(ntest); n_train = (AW+1)'(ntrain); start = 1'b1; res_ready = 1'b0;
        forever begin
            @(negedge clk);
            c++;
            start = busy_start && (c == nt + 5);
            if (start) n_test = 16'd1;
            res_ready = ($urandom_range(99) < pct);
            if (c == abort_c) begin
                rst = 1'b1;
                @(negedge clk);
                chk_reset_vals("abort");
                chk("abort_knn_rst", 64'(knn_rst), 1);
                rst = 1'b0;
                return;
            end
            if (done) begin done_cnt++; if (done_c < 0) done_c = c; end
            chk("knn_rst", 64'(knn_rst), 64'(nt > 0 && c == 1));
            chk("test_rd", 64'(test_rd), 64'(c >= 2 && c <= nt + 1));
            if (c >= 2 && c <= nt + 1) chk("test_addr", 64'(test_addr), 64'(c - 2));
            if (c >= 3 && c <= nt + 2) begin
                chk("load_sel", 64'(knn_solver_sel), 64'(c - 3));
                chk("load_data", 64'(knn_data1), 64'(test_mem[c - 3]));
            end else if (nt == 0 || c <= dk) begin
                chk("idle_sel", 64'(knn_solver_sel), 64'(16'hFFFF));
            end
            chk("train_rd", 64'(train_rd), 64'(nt > 0 && c >= nt + 3 && c <= nt + nn + 2));
            if (nt > 0 && c >= nt + 3 && c <= nt + nn + 2)
                chk("train_addr", 64'(train_addr), 64'(c - nt - 3));
            chk("knn_valid", 64'(knn_valid), 64'(nt > 0 && c >= nt + 4 && c <= nt + nn + 3));
            if (nt > 0 && c >= nt + 4 && c <= nt + nn + 3)
                chk("knn_data2", 64'(knn_data2), 64'(train_mem[c - nt - 4]));
            chk("knn_done", 64'(knn_done), 64'(c == dk));
            chk("busy", 64'(busy), 64'(done_c < 0 || c <= done_c));
            if (c > dk && res_valid)
                chk("rd_sel", 64'({knn_solver_sel, knn_sel}), 64'({res_solver, res_rank}));
            if (prev_stall) begin
                chk("hold_valid", 64'(res_valid), 1);
                chk("hold_res", 64'({res_data, res_solver, res_rank}), 64'({p_d, p_s, p_r}));
            end
            prev_stall = res_valid && !res_ready;
            p_d = res_data; p_s = res_solver; p_r = res_rank;
            if (res_valid && res_ready) begin
                rq_s.push_back(int'(res_solver));
                rq_r.push_back(int'(res_rank));
                rq_d.push_back(int'(res_data));
                last_hs = c;
            end
            if (done_c >= 0 && c == done_c + 1) begin
                chk("done_low", 64'(done), 0);
                break;
            end
            if (c > fin_c + 3000) begin
                chk("timeout", 64'(c), 64'(fin_c));
                break;
            end
        end
        last_done_c = done_c;
        chk("done_count", 64'(done_cnt), 1);
        chk("n_results", 64'(rq_s.size()), 64'(nt * HW_K));
        if (pct >= 100) chk("done_cycle", 64'(done_c), 64'(fin_c));
        if (nt > 0) chk("done_after_last", 64'(done_c > last_hs), 1);
        for (int i = 0; i < rq_s.size() && i < nt * HW_K; i++) begin
            chk("res_solver", 64'(rq_s[i]), 64'(i / HW_K));
            chk("res_rank", 64'(rq_r[i]), 64'(i % HW_K));
            chk("res_data", 64'(rq_d[i]), 64'(exp_lbl(i / HW_K, i % HW_K, nn)));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < (1 << AW); i++) begin
            test_mem[i]  = $urandom;
            train_mem[i] = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; res_ready = 1'b0; n_test = 16'd2; n_train = '0;
        fill_random();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_reset_vals("reset");
            chk("reset_knn_rst", 64'(knn_rst), 1);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset_busy", 64'(busy), 0);

        // Basic batch with hand-picked low bytes: streamed xor = 8'h1F.
        test_mem[0] = 32'hA5A5_0011;
        test_mem[1] = 32'h1234_5622;
        train_mem[0] = 32'hDEAD_0001; train_mem[1] = 32'hBEEF_0002; train_mem[2] = 32'h0000_0104;
        train_mem[3] = 32'h7777_0008; train_mem[4] = 32'h0101_0010;
        run_batch(2, 5, 100, -1, 0);
        chk("lit_res0", 64'(rq_d.size() > 0 ? rq_d[0] : -1), 64'(8'h0E));
        chk("lit_res13", 64'(rq_d.size() > 13 ? rq_d[13] : -1), 64'(8'h40));
        chk("lit_done_cycle", 64'(last_done_c), 64'd64);

        fill_random();
        run_batch(4, 17, 30, -1, 0);
        run_batch(3, 9, 30, -1, 1);
        run_batch(0, 5, 100, -1, 0);
        run_batch(2, 0, 100, -1, 0);
        run_batch(9, 6, 50, -1, 0);
        run_batch(3, 10, 100, 10, 0);
        run_batch(3, 10, 100, -1, 0);
        run_batch(2, 4, 100, 30, 0);
        run_batch(2, 4, 70, -1, 0);
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_batch(int'($urandom_range(6)), int'($urandom_range(20)),
                      int'($urandom_range(100, 20)), -1, 1'($urandom_range(1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
